// File: rtl/mc_controller_hs_if.sv
// rtl/mc_controller_hs_if.sv - control and memory-handshake bundle between mc_controller_hs and the datapath
interface mc_controller_hs_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             memread;
    logic             memwrite;
    logic             IorD;
    logic             IRwrite;
    logic             memtoreg;
    logic             regwrite;
    logic             regdst;
    logic             alusrcA;
    logic [1:0]       alusrcB;
    logic [1:0]       pcsrc;
    logic             pcEn;
    logic [2:0]       alucontrol;
    logic [CNT_W-1:0] instr_retired;
    logic             fault;
    logic [3:0]       state_dbg;

    modport master (
        input  op, funct, zero, mem_ready,
        output memread, memwrite, IorD, IRwrite, memtoreg, regwrite, regdst,
               alusrcA, alusrcB, pcsrc, pcEn, alucontrol, instr_retired, fault, state_dbg
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  memread, memwrite, IorD, IRwrite, memtoreg, regwrite, regdst,
               alusrcA, alusrcB, pcsrc, pcEn, alucontrol, instr_retired, fault, state_dbg
    );
endinterface

// File: rtl/mc_controller_hs.sv
// rtl/mc_controller_hs.sv - multicycle MIPS control FSM with memory handshake; MC_TIMEOUT_EN adds a memory-wait timeout
module mc_controller_hs #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    mc_controller_hs_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_FAULT   = 4'd12
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mc_controller_hs: TIMEOUT must be within 1..255");
    end

    state_t           r_state;
    logic             r_is_sw;
    logic             r_is_bne;
    logic             r_fault;
    logic [CNT_W-1:0] r_retired;

    logic       w_mem_wait;
    logic       w_timeout;
    logic       w_retire;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;

    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                        && !bus.mem_ready;

`ifdef MC_TIMEOUT_EN
    logic [7:0] r_wait;
    // r_wait counts earlier wait cycles, so this cycle is the TIMEOUT-th one
    assign w_timeout = w_mem_wait && (r_wait == 8'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BRANCH) ||
                      (r_state == S_ADDIWB) || (r_state == S_JUMP) ||
                      ((r_state == S_MEMWR) && bus.mem_ready);

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = 3'b000;
        case (bus.funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_is_sw   <= 1'b0;
            r_is_bne  <= 1'b0;
            r_fault   <= 1'b0;
            r_retired <= '0;
`ifdef MC_TIMEOUT_EN
            r_wait    <= 8'd0;
`endif
        end else begin
`ifdef MC_TIMEOUT_EN
            r_wait <= w_mem_wait ? r_wait + 8'd1 : 8'd0;
`endif
            if (w_retire) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_DECODE: begin
                    // op is only valid here, so remember what later states need from it
                    r_is_sw  <= (bus.op == 6'b101011);
                    r_is_bne <= (bus.op == 6'b000101);
                    case (bus.op)
                        6'b100011, 6'b101011: r_state <= S_MEMADR;
                        6'b000000:            r_state <= S_EXECUTE;
                        6'b000100, 6'b000101: r_state <= S_BRANCH;
                        6'b001000:            r_state <= S_ADDIEX;
                        6'b000010:            r_state <= S_JUMP;
                        default: begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: r_state <= r_is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (bus.mem_ready) begin
                        r_state <= S_MEMWB;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        r_state <= S_FETCH;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    if (w_funct_ok) begin
                        r_state <= S_ALUWB;
                    end else begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_FAULT:  r_state <= S_FAULT;
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    // Decoded from state and gated by reset so an asserted reset drops requests immediately
    always_comb begin
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.IorD       = 1'b0;
        bus.IRwrite    = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.alusrcA    = 1'b0;
        bus.alusrcB    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.pcEn       = 1'b0;
        bus.alucontrol = 3'b000;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    bus.memread    = 1'b1;
                    bus.alusrcB    = 2'b01;
                    bus.alucontrol = 3'b010;
                    bus.IRwrite    = bus.mem_ready;
                    bus.pcEn       = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alusrcB    = 2'b11;
                    bus.alucontrol = 3'b010;
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alusrcA    = 1'b1;
                    bus.alusrcB    = 2'b10;
                    bus.alucontrol = 3'b010;
                end
                S_MEMRD: begin
                    bus.memread = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    bus.memwrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    bus.alusrcA    = 1'b1;
                    bus.alucontrol = w_funct_alu;
                end
                S_ALUWB: begin
                    bus.regwrite = 1'b1;
                    bus.regdst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alusrcA    = 1'b1;
                    bus.alucontrol = 3'b110;
                    bus.pcsrc      = 2'b01;
                    bus.pcEn       = r_is_bne ? ~bus.zero : bus.zero;
                end
                S_ADDIWB: bus.regwrite = 1'b1;
                S_JUMP: begin
                    bus.pcsrc = 2'b10;
                    bus.pcEn  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state_dbg     = r_state;
    assign bus.fault         = r_fault;
    assign bus.instr_retired = r_retired;

endmodule
